// File: rtl/controlador_memoria_datos.sv
// ============================================================================
// Module   : controlador_memoria_datos
// Brief    : Sequencer that drives a 2^ANCHO_DIR x ANCHO_DATOS data memory.
//            Handles single-byte load/store and autonomous block copy/fill,
//            generating registered activa/guardar strobes with the address
//            and data held stable for a full cycle before guardar rises.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module controlador_memoria_datos #(
  parameter int ANCHO_DATOS = 8,
  parameter int ANCHO_DIR   = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inicio,
  input  logic [1:0]             operacion,
  input  logic [ANCHO_DIR-1:0]   dirOrigen,
  input  logic [ANCHO_DIR-1:0]   dirDestino,
  input  logic [ANCHO_DIR:0]     longitud,
  input  logic [ANCHO_DATOS-1:0] datoEscritura,
  output logic                   ocupado,
  output logic                   hecho,
  output logic                   error,
  output logic [ANCHO_DATOS-1:0] datoLeido,
  output logic [ANCHO_DIR-1:0]   direccionMemoria,
  output logic [ANCHO_DATOS-1:0] entradaDatos,
  output logic                   guardar,
  output logic                   activa,
  input  logic [ANCHO_DATOS-1:0] salidaDatos
);

  localparam int                 PROFUNDIDAD = 1 << ANCHO_DIR;
  localparam logic [ANCHO_DIR:0] LONG_MAX    = (ANCHO_DIR+1)'(PROFUNDIDAD);
  localparam logic [ANCHO_DIR:0] UNO         = (ANCHO_DIR+1)'(1);

  localparam logic [1:0] OP_CARGA   = 2'b00;
  localparam logic [1:0] OP_GUARDA  = 2'b01;
  localparam logic [1:0] OP_COPIA   = 2'b10;
  localparam logic [1:0] OP_RELLENO = 2'b11;

  typedef enum logic [2:0] {
    REPOSO = 3'd0,
    LEER   = 3'd1,
    PREP   = 3'd2,
    PULSO  = 3'd3,
    FIN    = 3'd4
  } estado_t;

  estado_t                estado_q;
  logic [1:0]             op_q;
  logic [ANCHO_DIR-1:0]   orig_q;
  logic [ANCHO_DIR-1:0]   dest_q;
  logic [ANCHO_DIR:0]     len_q;
  logic [ANCHO_DATOS-1:0] dato_q;
  logic [ANCHO_DIR:0]     idx_q;
  logic                   hecho_q;
  logic                   error_q;
  logic [ANCHO_DATOS-1:0] leido_q;
  logic [ANCHO_DIR-1:0]   dir_q;
  logic [ANCHO_DATOS-1:0] datos_q;
  logic                   guardar_q;
  logic                   activa_q;

  // Next byte index and the wrap-around addresses derived from it
  logic [ANCHO_DIR:0]     idx_d;
  logic [ANCHO_DIR-1:0]   dir_dest_act_d;
  logic [ANCHO_DIR-1:0]   dir_dest_sig_d;
  logic [ANCHO_DIR-1:0]   dir_orig_sig_d;
  logic                   long_invalida_d;

  assign idx_d           = idx_q + UNO;
  assign dir_dest_act_d  = dest_q + idx_q[ANCHO_DIR-1:0];
  assign dir_dest_sig_d  = dest_q + idx_d[ANCHO_DIR-1:0];
  assign dir_orig_sig_d  = orig_q + idx_d[ANCHO_DIR-1:0];
  assign long_invalida_d = (longitud == '0) || (longitud > LONG_MAX);

  // Command sequencer: latches commands in REPOSO and walks bytes through
  // LEER (capture), PREP (set address/data) and PULSO (write strobe)
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q  <= REPOSO;
      op_q      <= '0;
      orig_q    <= '0;
      dest_q    <= '0;
      len_q     <= '0;
      dato_q    <= '0;
      idx_q     <= '0;
      hecho_q   <= 1'b0;
      error_q   <= 1'b0;
      leido_q   <= '0;
      dir_q     <= '0;
      datos_q   <= '0;
      guardar_q <= 1'b0;
      activa_q  <= 1'b0;
    end else begin
      hecho_q <= 1'b0;
      case (estado_q)
        REPOSO: begin
          guardar_q <= 1'b0;
          activa_q  <= 1'b0;
          if (inicio) begin
            op_q    <= operacion;
            orig_q  <= dirOrigen;
            dest_q  <= dirDestino;
            len_q   <= longitud;
            dato_q  <= datoEscritura;
            idx_q   <= '0;
            error_q <= 1'b0;
            if (operacion == OP_CARGA) begin
              dir_q    <= dirOrigen;
              estado_q <= LEER;
            end else if (operacion == OP_GUARDA) begin
              dir_q    <= dirDestino;
              datos_q  <= datoEscritura;
              activa_q <= 1'b1;
              estado_q <= PREP;
            end else if (long_invalida_d) begin
              // Zero or oversize block: complete without touching memory
              error_q  <= (longitud > LONG_MAX);
              estado_q <= FIN;
            end else if (operacion == OP_COPIA) begin
              dir_q    <= dirOrigen;
              estado_q <= LEER;
            end else begin
              dir_q    <= dirDestino;
              datos_q  <= datoEscritura;
              activa_q <= 1'b1;
              estado_q <= PREP;
            end
          end
        end

        LEER: begin
          if (op_q == OP_CARGA) begin
            leido_q  <= salidaDatos;
            hecho_q  <= 1'b1;
            estado_q <= REPOSO;
          end else begin
            // Copy: captured byte becomes write data for the destination
            datos_q  <= salidaDatos;
            dir_q    <= dir_dest_act_d;
            activa_q <= 1'b1;
            estado_q <= PREP;
          end
        end

        PREP: begin
          guardar_q <= 1'b1;
          estado_q  <= PULSO;
        end

        PULSO: begin
          guardar_q <= 1'b0;
          if ((op_q == OP_GUARDA) || (idx_d == len_q)) begin
            activa_q <= 1'b0;
            hecho_q  <= 1'b1;
            estado_q <= REPOSO;
          end else begin
            idx_q <= idx_d;
            if (op_q == OP_COPIA) begin
              activa_q <= 1'b0;
              dir_q    <= dir_orig_sig_d;
              estado_q <= LEER;
            end else begin
              // Fill keeps activa high; guardar falls as the address moves
              dir_q    <= dir_dest_sig_d;
              datos_q  <= dato_q;
              estado_q <= PREP;
            end
          end
        end

        FIN: begin
          hecho_q  <= 1'b1;
          estado_q <= REPOSO;
        end

        default: begin
          guardar_q <= 1'b0;
          activa_q  <= 1'b0;
          estado_q  <= REPOSO;
        end
      endcase
    end
  end

  assign ocupado          = (estado_q != REPOSO);
  assign hecho            = hecho_q;
  assign error            = error_q;
  assign datoLeido        = leido_q;
  assign direccionMemoria = dir_q;
  assign entradaDatos     = datos_q;
  assign guardar          = guardar_q;
  assign activa           = activa_q;

endmodule

`default_nettype wire

// File: tb/tb_controlador_memoria_datos.sv
// ============================================================================
// Module   : tb_controlador_memoria_datos
// Brief    : Self-checking bench for controlador_memoria_datos with a
//            behavioural memory and an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controlador_memoria_datos;

  logic       clk = 1'b0;
  logic       reset;
  logic       inicio;
  logic [1:0] operacion;
  logic [6:0] dirOrigen, dirDestino;
  logic [7:0] longitud, datoEscritura;
  logic       ocupado, hecho, error, guardar, activa;
  logic [7:0] datoLeido, entradaDatos, salidaDatos;
  logic [6:0] direccionMemoria;

  int checks   = 0;
  int failures = 0;

  controlador_memoria_datos #(.ANCHO_DATOS(8), .ANCHO_DIR(7)) dut (
    .clk(clk), .reset(reset), .inicio(inicio), .operacion(operacion),
    .dirOrigen(dirOrigen), .dirDestino(dirDestino), .longitud(longitud),
    .datoEscritura(datoEscritura), .ocupado(ocupado), .hecho(hecho),
    .error(error), .datoLeido(datoLeido), .direccionMemoria(direccionMemoria),
    .entradaDatos(entradaDatos), .guardar(guardar), .activa(activa),
    .salidaDatos(salidaDatos)
  );

  always #5 clk = ~clk;

  // Behavioural memory: writes on rising guardar while activa, async read
  logic [7:0] mem      [128];
  logic [7:0] init_img [128];
  logic       do_init = 1'b0;

  always @(posedge guardar or posedge do_init) begin
    if (do_init) begin
      for (int i = 0; i < 128; i++) mem[i] = init_img[i];
    end else if (activa === 1'b1) begin
      mem[direccionMemoria] = entradaDatos;
    end
  end

  assign salidaDatos = mem[direccionMemoria];

  // Reference model state
  logic [7:0] ref_mem [128];
  logic [7:0] exp_leido;
  logic       exp_error;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write-timing monitor: guardar is a single-cycle pulse with activa high
  // and the address/data unchanged from the preceding cycle
  logic       prev_g = 1'b0;
  logic [6:0] prev_a = '0;
  logic [7:0] prev_d = '0;
  always @(negedge clk) begin
    if (guardar === 1'b1) begin
      chk("guardar_single_cycle", {31'd0, prev_g}, 32'd0);
      chk("activa_with_guardar", {31'd0, activa}, 32'd1);
      chk("addr_stable", {25'd0, direccionMemoria}, {25'd0, prev_a});
      chk("data_stable", {24'd0, entradaDatos}, {24'd0, prev_d});
    end
    prev_g = (guardar === 1'b1);
    prev_a = direccionMemoria;
    prev_d = entradaDatos;
  end

  // Issue one command, update the model, and check timing and results
  task automatic do_cmd(input logic [1:0] op, input logic [6:0] o, input logic [6:0] d,
                        input logic [7:0] L, input logic [7:0] v, input bit poke);
    int exp_lat, exp_pulses, k, n_ocup, n_g;
    logic [6:0] s, t;
    exp_pulses = 0;
    exp_error  = 1'b0;
    if (op == 2'b00) begin
      exp_lat   = 1;
      exp_leido = ref_mem[o];
    end else if (op == 2'b01) begin
      exp_lat    = 2;
      exp_pulses = 1;
      ref_mem[d] = v;
    end else if (L == 0 || L > 128) begin
      exp_lat   = 1;
      exp_error = (L > 128);
    end else begin
      exp_lat    = (op == 2'b10) ? 3 * int'(L) : 2 * int'(L);
      exp_pulses = int'(L);
      for (int i = 0; i < int'(L); i++) begin
        s = 7'((int'(o) + i) % 128);
        t = 7'((int'(d) + i) % 128);
        ref_mem[t] = (op == 2'b10) ? ref_mem[s] : v;
      end
    end

    @(negedge clk);
    operacion = op; dirOrigen = o; dirDestino = d; longitud = L; datoEscritura = v;
    inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    k = 0; n_ocup = 0; n_g = 0;
    while (!hecho && k < 1000) begin
      n_ocup += int'(ocupado);
      n_g    += int'(guardar);
      if (poke && k == 2) begin
        inicio = 1'b1; operacion = 2'b01; dirDestino = d + 7'd1; datoEscritura = ~v;
      end
      if (poke && k == 3) inicio = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    chk("hecho_latency", k, exp_lat);
    chk("ocupado_cycles", n_ocup, exp_lat);
    chk("guardar_pulses", n_g, exp_pulses);
    chk("ocupado_low_at_hecho", {31'd0, ocupado}, 32'd0);
    chk("error_flag", {31'd0, error}, {31'd0, exp_error});
    chk("datoLeido", {24'd0, datoLeido}, {24'd0, exp_leido});
    @(posedge clk); #1;
    chk("hecho_single_pulse", {31'd0, hecho}, 32'd0);
  endtask

  task automatic check_mem_image();
    int mism;
    mism = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("mem_image_mismatches", mism, 0);
  endtask

  initial begin
    logic [1:0] rop;
    logic [7:0] rl;
    int r;

    reset = 1'b1; inicio = 1'b0; operacion = '0; dirOrigen = '0; dirDestino = '0;
    longitud = '0; datoEscritura = '0;
    for (int i = 0; i < 128; i++) begin
      init_img[i] = 8'($urandom);
      ref_mem[i]  = init_img[i];
    end
    #1 do_init = 1'b1;
    #1 do_init = 1'b0;
    exp_leido = '0; exp_error = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs_zero",
        {7'd0, ocupado, hecho, error, datoLeido, direccionMemoria, entradaDatos, guardar, activa},
        32'd0);
    @(negedge clk); reset = 1'b0;

    // Store then load
    do_cmd(2'b01, 7'h00, 7'h10, 8'd0, 8'hA5, 1'b0);
    do_cmd(2'b00, 7'h10, 7'h00, 8'd0, 8'h00, 1'b0);
    chk("load_after_store", {24'd0, datoLeido}, 32'hA5);

    // Fill across the top of the address space
    do_cmd(2'b11, 7'h00, 7'h7E, 8'd4, 8'h3C, 1'b0);
    chk("fill_7E", {24'd0, mem[7'h7E]}, 32'h3C);
    chk("fill_7F", {24'd0, mem[7'h7F]}, 32'h3C);
    chk("fill_00", {24'd0, mem[7'h00]}, 32'h3C);
    chk("fill_01", {24'd0, mem[7'h01]}, 32'h3C);
    chk("fill_02_untouched", {24'd0, mem[7'h02]}, {24'd0, init_img[2]});

    // Copy three bytes, with a stray inicio mid-operation
    for (int i = 0; i < 3; i++) do_cmd(2'b01, 7'h00, 7'(i), 8'd0, 8'(i + 1), 1'b0);
    do_cmd(2'b10, 7'h00, 7'h40, 8'd3, 8'h00, 1'b1);
    chk("copy_40", {24'd0, mem[7'h40]}, 32'd1);
    chk("copy_41", {24'd0, mem[7'h41]}, 32'd2);
    chk("copy_42", {24'd0, mem[7'h42]}, 32'd3);

    // Degenerate lengths and error stickiness
    do_cmd(2'b10, 7'h05, 7'h50, 8'd0, 8'h00, 1'b0);
    do_cmd(2'b10, 7'h05, 7'h50, 8'd200, 8'h00, 1'b0);
    do_cmd(2'b11, 7'h05, 7'h50, 8'd129, 8'h11, 1'b0);
    do_cmd(2'b00, 7'h41, 7'h00, 8'd0, 8'h00, 1'b0);
    check_mem_image();

    // Reset during PULSO of fill byte 1
    for (int i = 0; i < 3; i++) do_cmd(2'b01, 7'h00, 7'(7'h20 + i), 8'd0, 8'h00, 1'b0);
    @(negedge clk);
    operacion = 2'b11; dirDestino = 7'h20; longitud = 8'd4; datoEscritura = 8'h77;
    inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("pulse_byte1_guardar", {31'd0, guardar}, 32'd1);
    chk("pulse_byte1_addr", {25'd0, direccionMemoria}, 32'h21);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midop_reset_outputs_zero",
        {7'd0, ocupado, hecho, error, datoLeido, direccionMemoria, entradaDatos, guardar, activa},
        32'd0);
    chk("midop_byte1_written", {24'd0, mem[7'h21]}, 32'h77);
    chk("midop_byte2_untouched", {24'd0, mem[7'h22]}, 32'h00);
    ref_mem[7'h20] = 8'h77; ref_mem[7'h21] = 8'h77;
    exp_leido = '0; exp_error = 1'b0;
    @(negedge clk); reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_hecho_after_reset", {31'd0, hecho}, 32'd0);
    end

    // Randomized commands against the reference model
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom);
      r   = int'($urandom_range(0, 9));
      if (r == 0)      rl = 8'd0;
      else if (r == 1) rl = 8'($urandom_range(129, 255));
      else if (r == 2) rl = 8'd128;
      else             rl = 8'($urandom_range(1, 20));
      do_cmd(rop, 7'($urandom), 7'($urandom), rl, 8'($urandom), 1'b0);
    end
    check_mem_image();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
